// File: rtl/rgb_pwm_ctrl.sv
// RGB LED PWM controller: two debounced buttons select mode and channel mask,
// a ready/valid port loads per-channel duty values that take effect at PWM period boundaries.
module rgb_pwm_ctrl #(
  parameter int PRESCALE_W = 4,
  parameter int DEBOUNCE_W = 16,
  parameter int BLINK_W    = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode_n,
  input  logic       btn_color_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_sel,
  input  logic [7:0] cfg_duty,
  output logic [2:0] rgb_pwm,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam logic [DEBOUNCE_W-1:0] DEB_ONE = DEBOUNCE_W'(1'b1);
  localparam logic [DEBOUNCE_W-1:0] DEB_MAX = {DEBOUNCE_W{1'b1}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1'b1);
  localparam logic [BLINK_W-1:0]    BLK_ONE = BLINK_W'(1'b1);

  function automatic logic [2:0] next_mask(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      3'b111:  nxt = 3'b001;
      3'b001:  nxt = 3'b010;
      3'b010:  nxt = 3'b100;
      default: nxt = 3'b111;
    endcase
    return nxt;
  endfunction

  function automatic logic [7:0] breathe_scale(input logic [7:0] duty, input logic [7:0] env);
    logic [15:0] prod;
    prod = {8'h00, duty} * {8'h00, env};
    return prod[15:8];
  endfunction

  logic [1:0]                 btn_raw_s;
  logic [1:0]                 sync1_r;
  logic [1:0]                 sync2_r;
  logic [1:0]                 stable_r;
  logic [1:0]                 press_r;
  logic [1:0][DEBOUNCE_W-1:0] deb_cnt_r;
  logic                       mode_press_s;
  logic                       color_press_s;

  logic [PRESCALE_W-1:0]      presc_r;
  logic [7:0]                 pwm_cnt_r;
  logic [BLINK_W-1:0]         blink_r;
  logic                       tick_s;
  logic                       boundary_s;
  logic [7:0]                 env_r;
  logic                       env_up_r;

  mode_e                      state_r;
  mode_e                      state_nxt_s;
  logic [2:0]                 mask_r;

  logic                       pending_r;
  logic [7:0]                 sh_duty_r;
  logic [1:0]                 sh_sel_r;
  logic [2:0][7:0]            duty_r;
  logic                       xfer_s;

  logic [2:0][7:0]            eff_s;
  logic [2:0]                 rgb_r;

  assign btn_raw_s     = {btn_color_n, btn_mode_n};
  assign mode_press_s  = press_r[0];
  assign color_press_s = press_r[1];

  // Two-flop synchronizers for the asynchronous buttons (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: press_r pulses one cycle after a stable high-to-low transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r  <= 2'b11;
      press_r   <= 2'b00;
      deb_cnt_r <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2_r[b] != stable_r[b]) begin
          if (deb_cnt_r[b] == DEB_MAX) begin
            stable_r[b]  <= sync2_r[b];
            deb_cnt_r[b] <= '0;
            press_r[b]   <= ~sync2_r[b];
          end else begin
            deb_cnt_r[b] <= deb_cnt_r[b] + DEB_ONE;
            press_r[b]   <= 1'b0;
          end
        end else begin
          deb_cnt_r[b] <= '0;
          press_r[b]   <= 1'b0;
        end
      end
    end
  end

  assign tick_s     = &presc_r;
  assign boundary_s = tick_s && (pwm_cnt_r == 8'hFF);

  // Free-running prescaler, PWM counter and blink counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r   <= '0;
      pwm_cnt_r <= 8'h00;
      blink_r   <= '0;
    end else begin
      presc_r <= presc_r + PRE_ONE;
      blink_r <= blink_r + BLK_ONE;
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + 8'd1;
      end else begin
        pwm_cnt_r <= pwm_cnt_r;
      end
    end
  end

  // Triangle envelope: endpoints are visited once, direction flips on reaching them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_r    <= 8'h00;
      env_up_r <= 1'b1;
    end else if (boundary_s) begin
      if (env_up_r) begin
        if (env_r == 8'hFF) begin
          env_r    <= 8'hFE;
          env_up_r <= 1'b0;
        end else begin
          env_r <= env_r + 8'd1;
        end
      end else begin
        if (env_r == 8'h00) begin
          env_r    <= 8'h01;
          env_up_r <= 1'b1;
        end else begin
          env_r <= env_r - 8'd1;
        end
      end
    end else begin
      env_r    <= env_r;
      env_up_r <= env_up_r;
    end
  end

  // Mode FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MODE_OFF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Mode FSM next state: one step per accepted mode press.
  always_comb begin
    state_nxt_s = state_r;
    if (mode_press_s) begin
      case (state_r)
        MODE_OFF:     state_nxt_s = MODE_SOLID;
        MODE_SOLID:   state_nxt_s = MODE_BLINK;
        MODE_BLINK:   state_nxt_s = MODE_BREATHE;
        MODE_BREATHE: state_nxt_s = MODE_OFF;
        default:      state_nxt_s = MODE_OFF;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Mode FSM outputs: per-channel effective duty, masked channels forced dark.
  always_comb begin
    logic [7:0] lvl_s;
    eff_s = '0;
    for (int ch = 0; ch < 3; ch++) begin
      lvl_s = 8'h00;
      case (state_r)
        MODE_OFF:     lvl_s = 8'h00;
        MODE_SOLID:   lvl_s = duty_r[ch];
        MODE_BLINK:   lvl_s = blink_r[BLINK_W-1] ? 8'h00 : duty_r[ch];
        MODE_BREATHE: lvl_s = breathe_scale(duty_r[ch], env_r);
        default:      lvl_s = 8'h00;
      endcase
      eff_s[ch] = mask_r[ch] ? lvl_s : 8'h00;
    end
  end

  // Channel mask rotates on each color press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r <= 3'b111;
    end else if (color_press_s) begin
      mask_r <= next_mask(mask_r);
    end else begin
      mask_r <= mask_r;
    end
  end

  assign xfer_s    = cfg_valid && !pending_r;
  assign cfg_ready = ~pending_r;

  // Shadow capture; a transfer is only possible with pending clear, so it never races the commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
      sh_duty_r <= 8'h80;
      sh_sel_r  <= 2'd0;
    end else if (xfer_s && (cfg_sel != 2'd3)) begin
      pending_r <= 1'b1;
      sh_duty_r <= cfg_duty;
      sh_sel_r  <= cfg_sel;
    end else if (boundary_s && pending_r) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Active duties change only at a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r <= {8'h80, 8'h80, 8'h80};
    end else if (boundary_s && pending_r) begin
      case (sh_sel_r)
        2'd0:    duty_r[0] <= sh_duty_r;
        2'd1:    duty_r[1] <= sh_duty_r;
        2'd2:    duty_r[2] <= sh_duty_r;
        default: duty_r    <= duty_r;
      endcase
    end else begin
      duty_r <= duty_r;
    end
  end

  // Registered PWM compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r <= 3'b000;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        rgb_r[ch] <= (eff_s[ch] > pwm_cnt_r);
      end
    end
  end

  assign rgb_pwm = rgb_r;
  assign mode    = state_r;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Randomised bench for rgb_pwm_ctrl; outputs are compared every cycle against a
// time-indexed reference model driven by the same stimulus.
module tb_rgb_pwm_ctrl;

  localparam int PW        = 1;
  localparam int DW        = 2;
  localparam int BW        = 10;
  localparam int PERIOD    = 256 << PW;
  localparam int PRESS_LAT = 6;
  localparam int MIN_PRESS = 1 << DW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode_n = 1'b1;
  logic       btn_color_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_duty = 8'h00;
  logic [2:0] rgb_pwm;
  logic [1:0] mode;

  always #5 clk = ~clk;

  rgb_pwm_ctrl #(.PRESCALE_W(PW), .DEBOUNCE_W(DW), .BLINK_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode_n(btn_mode_n), .btn_color_n(btn_color_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_duty(cfg_duty),
    .rgb_pwm(rgb_pwm), .mode(mode)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: k is the number of clock edges since reset release.
  int         k;
  int         m_mode;
  logic [2:0] m_mask;
  int         m_duty [3];
  int         sh_duty, sh_sel;
  bit         m_pend;
  logic [2:0] m_rgb;
  int         mode_evt[$];
  int         color_evt[$];
  int         low_left [2];
  int         gap_left [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic int env_at(int j);
    int m = (j / PERIOD) % 510;
    return (m <= 255) ? m : 510 - m;
  endfunction

  function automatic int pwm_at(int j);
    return (j >> PW) % 256;
  endfunction

  function automatic int eff_at(int ch, int j);
    if (!m_mask[ch]) return 0;
    case (m_mode)
      1:       return m_duty[ch];
      2:       return ((j >> (BW - 1)) & 1) ? 0 : m_duty[ch];
      3:       return (m_duty[ch] * env_at(j)) / 256;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    k = 0; m_mode = 0; m_mask = 3'b111; m_pend = 0; m_rgb = 3'b000;
    sh_duty = 128; sh_sel = 0;
    for (int i = 0; i < 3; i++) m_duty[i] = 128;
    mode_evt.delete(); color_evt.delete();
    for (int b = 0; b < 2; b++) begin low_left[b] = 0; gap_left[b] = 0; end
  endtask

  task automatic model_edge();
    logic [2:0] r;
    bit xfer, commit;
    for (int ch = 0; ch < 3; ch++) r[ch] = (eff_at(ch, k) > pwm_at(k));
    xfer   = cfg_valid && !m_pend;
    commit = ((k + 1) % PERIOD == 0) && m_pend;
    k++;
    if (mode_evt.size() > 0 && mode_evt[0] == k) begin
      void'(mode_evt.pop_front());
      m_mode = (m_mode + 1) % 4;
    end
    if (color_evt.size() > 0 && color_evt[0] == k) begin
      void'(color_evt.pop_front());
      case (m_mask)
        3'b111:  m_mask = 3'b001;
        3'b001:  m_mask = 3'b010;
        3'b010:  m_mask = 3'b100;
        default: m_mask = 3'b111;
      endcase
    end
    if (commit) begin m_duty[sh_sel] = sh_duty; m_pend = 0; end
    if (xfer && cfg_sel != 2'd3) begin sh_duty = cfg_duty; sh_sel = cfg_sel; m_pend = 1; end
    m_rgb = r;
  endtask

  // One clock: drive buttons from the press plan, step the model, compare on the falling edge.
  task automatic cyc();
    btn_mode_n  = (low_left[0] > 0) ? 1'b0 : 1'b1;
    btn_color_n = (low_left[1] > 0) ? 1'b0 : 1'b1;
    for (int b = 0; b < 2; b++) begin
      if (low_left[b] > 0) begin
        low_left[b]--;
        if (low_left[b] == 0) gap_left[b] = 8;
      end else if (gap_left[b] > 0) begin
        gap_left[b]--;
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("rgb_pwm", rgb_pwm, m_rgb);
    check_eq("mode", mode, m_mode);
    check_eq("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic press(input int b, input int len);
    while (low_left[b] != 0 || gap_left[b] != 0) cyc();
    if (len >= MIN_PRESS) begin
      if (b == 0) mode_evt.push_back(k + 1 + PRESS_LAT);
      else        color_evt.push_back(k + 1 + PRESS_LAT);
    end
    low_left[b] = len;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] duty);
    bit done = 0;
    cfg_valid = 1'b1; cfg_sel = sel; cfg_duty = duty;
    for (int n = 0; n < 2 * PERIOD + 16 && !done; n++) begin
      done = cfg_ready;
      cyc();
    end
    cfg_valid = 1'b0;
    check_eq("cfg_accept", done, 1);
  endtask

  initial begin
    bit hs;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rgb", rgb_pwm, 3'b000);
    check_eq("rst_mode", mode, 0);
    check_eq("rst_ready", cfg_ready, 1);
    rst_n = 1'b1;

    // Held mode press, then a glitch and four full presses.
    press(0, 10);
    repeat (20) cyc();
    check_eq("mode_after_press", mode, 1);
    press(0, 3);
    repeat (20) cyc();
    check_eq("mode_after_glitch", mode, 1);
    for (int i = 0; i < 4; i++) press(0, 6);
    repeat (20) cyc();
    check_eq("mode_after_four", mode, 1);

    // SOLID: back-to-back duty writes, then a reserved-select write.
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd1, 8'hFF);
    repeat (3 * PERIOD) cyc();
    cfg_write(2'd3, 8'h5A);
    repeat (PERIOD) cyc();

    // Mask rotation.
    press(1, 5);
    repeat (PERIOD) cyc();
    for (int i = 0; i < 3; i++) press(1, 5);
    repeat (PERIOD) cyc();

    // BLINK then BREATHE at full duty.
    press(0, 5);
    repeat (2 * PERIOD) cyc();
    press(0, 5);
    for (int ch = 0; ch < 3; ch++) cfg_write(ch[1:0], 8'hFF);
    repeat (12 * PERIOD) cyc();

    // Random writes and button activity.
    for (int i = 0; i < 15000; i++) begin
      if (!cfg_valid && $urandom_range(0, 11) == 0) begin
        cfg_valid = 1'b1;
        cfg_sel   = 2'($urandom_range(0, 3));
        cfg_duty  = 8'($urandom);
      end
      for (int b = 0; b < 2; b++) begin
        if (low_left[b] == 0 && gap_left[b] == 0 && $urandom_range(0, 299) == 0)
          press(b, $urandom_range(1, 8));
      end
      hs = cfg_valid && cfg_ready;
      cyc();
      if (hs) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
    repeat (2 * PERIOD) cyc();

    // Asynchronous reset while a write is pending.
    cfg_write(2'd2, 8'h11);
    check_eq("pend_before_rst", cfg_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_rgb", rgb_pwm, 3'b000);
    check_eq("async_rst_mode", mode, 0);
    check_eq("async_rst_ready", cfg_ready, 1);
    model_reset();
    btn_mode_n = 1'b1; btn_color_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    press(0, 5);
    repeat (2 * PERIOD) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
